// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp: SPI responder emulating an 8-channel, 12-bit A2D converter.
// A frame's command selects the channel whose sample is returned in the next frame.
module a2d_spi_resp #(
    parameter logic [2:0]  RST_CHNNL = 3'd0,
    parameter int unsigned SYNC_STG  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [95:0] ana,
    output logic [2:0]  chnnl,
    output logic        cmd_rcvd,
    output logic        frm_err
);

    localparam int unsigned FRM_BITS = 16;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned SMP_W    = 12;
    localparam int unsigned CNT_MAX  = 31;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STG-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STG-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STG-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STG-1:0] vld_q, vld_d;
    logic                ss_hist_q, ss_hist_d;
    logic                sclk_hist_q, sclk_hist_d;
    logic                armed_q, armed_d;

    logic [15:0]         rx_shft_q, rx_shft_d;
    logic [15:0]         tx_shft_q, tx_shft_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                first_q, first_d;
    logic [2:0]          chnnl_q, chnnl_d;
    logic                cmd_rcvd_q, cmd_rcvd_d;
    logic                frm_err_q, frm_err_d;
    logic                miso_q, miso_d;

    logic                ss_s_c, sclk_s_c, mosi_s_c;
    logic                ss_fall_c, ss_rise_c, sclk_rise_c, sclk_fall_c;
    logic [SMP_W-1:0]    ana_sel_c;

    // Synchronizer shift and arming: a SS_n fall only counts once SS_n was seen high after reset
    always_comb begin
        ss_sync_d   = {ss_sync_q[SYNC_STG-2:0], SS_n};
        sclk_sync_d = {sclk_sync_q[SYNC_STG-2:0], SCLK};
        mosi_sync_d = {mosi_sync_q[SYNC_STG-2:0], MOSI};
        vld_d       = {vld_q[SYNC_STG-2:0], 1'b1};
        ss_hist_d   = ss_s_c;
        sclk_hist_d = sclk_s_c;
        armed_d     = armed_q | (vld_q[SYNC_STG-1] & ss_s_c);
    end

    // Synchronized levels, edge strobes and the addressed sample
    always_comb begin
        ss_s_c      = ss_sync_q[SYNC_STG-1];
        sclk_s_c    = sclk_sync_q[SYNC_STG-1];
        mosi_s_c    = mosi_sync_q[SYNC_STG-1];
        ss_fall_c   = armed_q & ss_hist_q & ~ss_s_c;
        ss_rise_c   = ~ss_hist_q & ss_s_c;
        sclk_rise_c = ~sclk_hist_q & sclk_s_c;
        sclk_fall_c = sclk_hist_q & ~sclk_s_c;
        ana_sel_c   = ana[SMP_W*chnnl_q +: SMP_W];
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ss_sync_q   <= '1;
            sclk_sync_q <= '1;
            mosi_sync_q <= '0;
            vld_q       <= '0;
            ss_hist_q   <= 1'b1;
            sclk_hist_q <= 1'b1;
            armed_q     <= 1'b0;
            rx_shft_q   <= '0;
            tx_shft_q   <= '0;
            bit_cnt_q   <= '0;
            first_q     <= 1'b0;
            chnnl_q     <= RST_CHNNL;
            cmd_rcvd_q  <= 1'b0;
            frm_err_q   <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ss_sync_q   <= ss_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            vld_q       <= vld_d;
            ss_hist_q   <= ss_hist_d;
            sclk_hist_q <= sclk_hist_d;
            armed_q     <= armed_d;
            rx_shft_q   <= rx_shft_d;
            tx_shft_q   <= tx_shft_d;
            bit_cnt_q   <= bit_cnt_d;
            first_q     <= first_d;
            chnnl_q     <= chnnl_d;
            cmd_rcvd_q  <= cmd_rcvd_d;
            frm_err_q   <= frm_err_d;
            miso_q      <= miso_d;
        end
    end

    // Next state: a frame spans SS_n fall to SS_n rise
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_fall_c) state_d = SHIFT;
            SHIFT:   if (ss_rise_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shift registers, bit count, channel latch and pulses; SS_n rise wins over SCLK edges
    always_comb begin
        rx_shft_d  = rx_shft_q;
        tx_shft_d  = tx_shft_q;
        bit_cnt_d  = bit_cnt_q;
        first_d    = first_q;
        chnnl_d    = chnnl_q;
        cmd_rcvd_d = 1'b0;
        frm_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall_c) begin
                    tx_shft_d = {4'h0, ana_sel_c};
                    bit_cnt_d = '0;
                    first_d   = 1'b1;
                end
            end
            SHIFT: begin
                if (ss_rise_c) begin
                    if (bit_cnt_q == CNT_W'(FRM_BITS)) begin
                        chnnl_d    = rx_shft_q[13:11];
                        cmd_rcvd_d = 1'b1;
                    end else begin
                        frm_err_d  = 1'b1;
                    end
                end else if (sclk_rise_c) begin
                    rx_shft_d = {rx_shft_q[14:0], mosi_s_c};
                    if (bit_cnt_q != CNT_W'(CNT_MAX)) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall_c) begin
                    if (first_q) begin
                        first_d = 1'b0;
                    end else begin
                        tx_shft_d = {tx_shft_q[14:0], 1'b0};
                    end
                end
            end
            default: ;
        endcase
        miso_d = (state_d == SHIFT) ? tx_shft_d[15] : 1'b0;
    end

    assign MISO     = miso_q;
    assign chnnl    = chnnl_q;
    assign cmd_rcvd = cmd_rcvd_q;
    assign frm_err  = frm_err_q;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// tb_a2d_spi_resp: SPI-master driven scoreboard bench for a2d_spi_resp.
module tb_a2d_spi_resp;

    localparam int HP = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [95:0] ana;
    logic [2:0]  chnnl;
    logic        cmd_rcvd;
    logic        frm_err;

    logic [11:0] ana_m [8];
    logic [2:0]  model_ch;
    logic [15:0] exp_q [$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_cmd  = 0;
    int          n_err  = 0;

    a2d_spi_resp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .ana      (ana),
        .chnnl    (chnnl),
        .cmd_rcvd (cmd_rcvd),
        .frm_err  (frm_err)
    );

    always #10 clk = ~clk;

    always_comb begin
        ana = '0;
        for (int n = 0; n < 8; n++) ana[12*n +: 12] = ana_m[n];
    end

    // Pulse counters (one count per high clk)
    always @(negedge clk) begin
        if (cmd_rcvd) n_cmd <= n_cmd + 1;
        if (frm_err)  n_err <= n_err + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One master frame; scored frames push the model response and compare on completion
    task automatic spi_frame(input logic [15:0] cmd, input int nbits, input int gap, input bit scored);
        logic [15:0] rsp;
        rsp = '0;
        if (scored) exp_q.push_back({4'h0, ana_m[model_ch]});
        SS_n = 1'b0;
        tick(HP);
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            MOSI = (i < 16) ? cmd[15-i] : 1'b0;
            tick(HP);
            SCLK = 1'b1;
            if (i < 16) rsp = {rsp[14:0], MISO};
            tick(HP);
        end
        SS_n = 1'b1;
        if (nbits == 16) model_ch = cmd[13:11];
        if (scored) begin
            if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
            else chk("rsp", {16'h0, rsp}, {16'h0, exp_q.pop_front()});
        end
        tick(gap);
    endtask

    initial begin
        int c0, e0;
        rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
        for (int n = 0; n < 8; n++) ana_m[n] = '0;
        model_ch = 3'd0;
        tick(3);
        chk("rst_chnnl", {29'h0, chnnl}, 32'd0);
        chk("rst_miso", {31'h0, MISO}, 32'd0);
        chk("rst_cmd", {31'h0, cmd_rcvd}, 32'd0);
        chk("rst_err", {31'h0, frm_err}, 32'd0);
        rst_n = 1'b1;
        tick(10);

        // First frame: response from reset channel, command selects ch5
        ana_m[0] = 12'h123; ana_m[5] = 12'hA5C;
        c0 = n_cmd; e0 = n_err;
        spi_frame(16'h2800, 16, 20, 1'b1);
        chk("f1_chnnl", {29'h0, chnnl}, 32'd5);
        chk("f1_cmd", n_cmd - c0, 1);
        chk("f1_err", n_err - e0, 0);

        // Second frame returns ch5; ignored command bits set, selects ch0
        spi_frame(16'hC7FF, 16, 20, 1'b1);
        chk("f2_chnnl", {29'h0, chnnl}, 32'd0);

        // Back-to-back channel sweep
        for (int n = 0; n < 8; n++) ana_m[n] = 12'(12'h101 * n);
        c0 = n_cmd; e0 = n_err;
        for (int n = 0; n < 8; n++) spi_frame({2'b00, 3'(n), 11'h0}, 16, (n == 7) ? 20 : 1, 1'b1);
        chk("sw_chnnl", {29'h0, chnnl}, 32'd7);
        chk("sw_cmd", n_cmd - c0, 8);
        chk("sw_err", n_err - e0, 0);

        // ana changes mid-frame while ch3 is addressed
        ana_m[3] = 12'h0F0;
        spi_frame(16'h1800, 16, 20, 1'b1);
        fork
            spi_frame(16'h1800, 16, 20, 1'b1);
            begin tick(120); ana_m[3] = 12'hF0F; end
        join
        spi_frame(16'h1800, 16, 20, 1'b1);

        // Short frame (8 bits, ch6) then overrun (17 bits, ch1): errors, channel held
        c0 = n_cmd; e0 = n_err;
        spi_frame(16'h3000, 8, 20, 1'b0);
        chk("short_err", n_err - e0, 1);
        chk("short_cmd", n_cmd - c0, 0);
        chk("short_chnnl", {29'h0, chnnl}, 32'd3);
        spi_frame(16'h0800, 17, 20, 1'b0);
        chk("ovr_err", n_err - e0, 2);
        chk("ovr_chnnl", {29'h0, chnnl}, 32'd3);
        spi_frame(16'h2000, 16, 20, 1'b1);

        // Reset mid-frame, then a partial frame after reset must be ignored
        SS_n = 1'b0;
        tick(HP);
        for (int i = 0; i < 10; i++) begin
            SCLK = 1'b0; MOSI = ~MOSI; tick(HP);
            SCLK = 1'b1; tick(HP);
        end
        rst_n = 1'b0;
        tick(2);
        chk("mrst_miso", {31'h0, MISO}, 32'd0);
        chk("mrst_chnnl", {29'h0, chnnl}, 32'd0);
        rst_n = 1'b1;
        model_ch = 3'd0;
        c0 = n_cmd; e0 = n_err;
        tick(10);
        for (int i = 0; i < 4; i++) begin
            SCLK = 1'b0; tick(HP);
            SCLK = 1'b1; tick(HP);
        end
        SS_n = 1'b1;
        tick(20);
        chk("post_rst_cmd", n_cmd - c0, 0);
        chk("post_rst_err", n_err - e0, 0);
        chk("post_rst_miso", {31'h0, MISO}, 32'd0);

        ana_m[0] = 12'h5A5;
        spi_frame(16'h2000, 16, 20, 1'b1);
        chk("rec_chnnl", {29'h0, chnnl}, 32'd4);
        chk("rec_cmd", n_cmd - c0, 1);
        chk("sb_left", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/a2d_spi_resp.md
Name: a2d_spi_resp

Overview:
- Clocked SPI responder that emulates an 8-channel, 12-bit A2D converter, sitting on the far end of the team's A2D SPI master link.
- Receives 16-bit commands on MOSI and returns the conversion result for the channel addressed in the previous frame. This matches the two-frame, pipelined command/response sequence the master issues.
- Used as the bench and FPGA stand-in for the real converter. Analog values come from a parallel input bus.

Parameters:
- RST_CHNNL, 3'd0, channel whose data is returned in the first frame after reset.
- SYNC_STG, 2, number of flops in the SS_n/SCLK/MOSI metastability synchronizers (legal values 2 or 3).

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  reset
- SS_n  in  1  active-low slave select from master
- SCLK  in  1  SPI clock from master; idle high
- MOSI  in  1  serial command from master, MSB first
- MISO  out  1  serial response to master, MSB first
- ana  in  96  channel samples; ch N = ana[12N+11:12N]
- chnnl  out  3  channel latched from the last complete frame
- cmd_rcvd  out  1  one-clk pulse when a complete 16-bit frame ends
- frm_err  out  1  one-clk pulse when a frame ends with a bit count other than 16

Behaviour:
Clock, reset and synchronization
- Reset rst_n, asynchronous, active-low; clock clk.
- SS_n, SCLK and MOSI each pass through SYNC_STG flops, plus one history flop for edge detection. Detected edges therefore lag the pins by SYNC_STG+1 clk.
- Minimum supported SCLK half-period is 6 clk (the master uses 16).

Reset values
- chnnl = RST_CHNNL.
- cmd_rcvd = 0, frm_err = 0, MISO = 0.
- rx_shft = 0, tx_shft = 0, bit_cnt = 0.
- Synchronizer flops for SS_n and SCLK reset to 1; the MOSI synchronizer resets to 0.
- State = IDLE.

State machine: IDLE, SHIFT
- IDLE, SS_n fall detected:
  - tx_shft <= {4'h0, ana[12*chnnl +: 12]}; the sample is captured only here.
  - bit_cnt <= 0, first <= 1, go to SHIFT.
- SHIFT, SCLK rise detected:
  - rx_shft <= {rx_shft[14:0], MOSI_sync}.
  - bit_cnt increments and saturates at 31.
- SHIFT, SCLK fall detected:
  - If first = 1: clear first; no shift. The MSB is already presented from SS_n fall.
  - Otherwise: tx_shft <= {tx_shft[14:0], 1'b0}.
- SHIFT, SS_n rise detected: return to IDLE.
  - If bit_cnt == 16: chnnl <= rx_shft[13:11] and pulse cmd_rcvd.
  - Otherwise: chnnl is unchanged and frm_err pulses.
- Simultaneous events: an SS_n rise takes priority over a same-cycle SCLK edge; the SCLK edge is ignored.

MISO and command decode
- MISO = tx_shft[15] while synchronized SS_n is low; 0 otherwise.
- MISO is a registered output and changes only on the clk after a detected SCLK fall or SS_n fall.
- Command format is {2'b00, chnnl[2:0], 11'h000}. Bits [15:14] and [10:0] are ignored; nonzero values there are not errors.

Pipelining and boundary conditions
- The response in frame k is for the channel received in frame k-1, or RST_CHNNL for the first frame after reset.
- Back-to-back frames (SS_n high for only 1 synchronized clk) are supported.
- ana changes during SHIFT do not affect the frame in progress.
- bit_cnt > 16 (master overrun) is an error: frm_err pulses and chnnl is held.
- Reset mid-frame returns to IDLE and restores all reset values. A following partial frame observed after reset (SS_n already low) is ignored until SS_n goes high and falls again.
- SCLK edges while in IDLE are ignored.

Test Plan:
- Reset, then one frame with MOSI=16'h2800 (ch5) and ana ch0=12'h123 -> MISO shifts 16'h0123; at SS_n rise cmd_rcvd pulses once and chnnl=5.
- Next frame with ana ch5=12'hA5C -> MISO returns 16'h0A5C. A master in the same codebase sequence (cmd frame, 1 clk gap, rsp frame) reads res=12'hA5C.
- Channel sweep 0..7 back-to-back with ana chN = 12'h100*N+N -> each frame returns the previous channel's value; no frm_err pulses.
- Change ana ch3 from 12'h0F0 to 12'hF0F mid-frame while addressed -> current frame returns 16'h00F0; the next frame returns 16'h0F0F.
- SS_n rises after 8 SCLK rises in a frame sending ch6 -> frm_err pulses, cmd_rcvd stays 0, chnnl unchanged. The next frame still returns the old channel's data.
- Assert rst_n low after 10 bits -> MISO=0, chnnl=RST_CHNNL, state IDLE. After SS_n high then low, a full frame completes normally.
